// File: rtl/sal_axi_mem_resp.sv
// sal_axi_mem_resp: AXI4 responder backed by an internal register-array memory.
// Independent read and write FSMs, each holding at most one outstanding burst.
module sal_axi_mem_resp #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // write address
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_16B    = 3'd4;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT_LOAD    = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  // Address bits outside the entry index are ignored, so the memory aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:IDX_W+4], awaddr[3:0],
                              araddr[ADDR_WIDTH-1:IDX_W+4], araddr[3:0]};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e            w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q,  wready_d;
  logic                bvalid_q,  bvalid_d;
  logic [ID_WIDTH-1:0] bid_q,     bid_d;
  logic [1:0]          bresp_q,   bresp_d;
  logic [ID_WIDTH-1:0] w_id_q,    w_id_d;
  logic [IDX_W-1:0]    w_idx_q,   w_idx_d;
  logic [7:0]          w_len_q,   w_len_d;
  logic [7:0]          w_cnt_q,   w_cnt_d;
  logic                w_err_q,   w_err_d;
  logic                w_err_beat;
  logic                mem_we;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    w_id_d     = w_id_q;
    w_idx_d    = w_idx_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    w_err_beat = w_err_q;
    mem_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_id_d    = awid;
          w_idx_d   = awaddr[IDX_W+3:4];
          w_len_d   = awlen;
          w_cnt_d   = '0;
          w_err_d   = (awsize != SIZE_16B) || (awburst != BURST_INCR);
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we     = !w_err_q;
          w_idx_d    = w_idx_q + 1'b1;
          w_cnt_d    = w_cnt_q + 1'b1;
          // Sticky error: a wlast that disagrees with the beat count poisons the burst.
          w_err_beat = w_err_q || (wlast != (w_cnt_q == w_len_q));
          w_err_d    = w_err_beat;
          if (wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_err_beat ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // NOTE: the storage array has no reset; clearing it would turn a plain
  // register file into thousands of reset-capable flops for no functional gain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic [ID_WIDTH-1:0]   rid_q,     rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [IDX_W-1:0]      r_idx_q,   r_idx_d;
  logic [7:0]            r_left_q,  r_left_d;
  logic [3:0]            r_lat_q,   r_lat_d;
  logic                  r_err_q,   r_err_d;
  logic [IDX_W-1:0]      r_idx_nxt;

  assign r_idx_nxt = r_idx_q + 1'b1;

  // Memory is sampled combinationally into rdata_d, so a same-edge write to
  // the same entry is not yet visible and the read returns the old contents.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_idx_d   = r_idx_q;
    r_left_d  = r_left_q;
    r_lat_d   = r_lat_q;
    r_err_d   = r_err_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          rid_d     = arid;
          r_idx_d   = araddr[IDX_W+3:4];
          r_left_d  = arlen;
          r_err_d   = (arsize != SIZE_16B) || (arburst != BURST_INCR);
          r_lat_d   = LAT_LOAD;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_lat_q == 4'd0) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_err_q ? '0 : mem_q[r_idx_q];
          rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (r_left_q == 8'd0);
          r_state_d = R_DATA;
        end else begin
          r_lat_d = r_lat_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = r_idx_nxt;
            r_left_d = r_left_q - 8'd1;
            rdata_d  = r_err_q ? '0 : mem_q[r_idx_nxt];
            rlast_d  = (r_left_q == 8'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      r_idx_q   <= '0;
      r_left_q  <= '0;
      r_lat_q   <= '0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      r_idx_q   <= r_idx_d;
      r_left_q  <= r_left_d;
      r_lat_q   <= r_lat_d;
      r_err_q   <= r_err_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_sal_axi_mem_resp.sv
// Self-checking bench for sal_axi_mem_resp: directed bursts against a
// transaction-level memory model with expected-response queues.
`timescale 1ns/1ps
module tb_sal_axi_mem_resp;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 128;
  localparam int DEPTH      = 256;
  localparam int RD_LAT     = 2;
  localparam int TMO        = 200;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [ID_WIDTH-1:0]     awid = '0;
  logic [ADDR_WIDTH-1:0]   awaddr = '0;
  logic [7:0]              awlen = '0;
  logic [2:0]              awsize = '0;
  logic [1:0]              awburst = '0;
  logic                    awvalid = 1'b0;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata = '0;
  logic [DATA_WIDTH/8-1:0] wstrb = '0;
  logic                    wlast = 1'b0;
  logic                    wvalid = 1'b0;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready = 1'b1;
  logic [ID_WIDTH-1:0]     arid = '0;
  logic [ADDR_WIDTH-1:0]   araddr = '0;
  logic [7:0]              arlen = '0;
  logic [2:0]              arsize = '0;
  logic [1:0]              arburst = '0;
  logic                    arvalid = 1'b0;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready = 1'b1;

  always #5 clk = ~clk;

  sal_axi_mem_resp #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_exp_t;

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } b_exp_t;

  r_exp_t                exp_r[$];
  b_exp_t                exp_b[$];
  logic [DATA_WIDTH-1:0] got_r[$];
  logic [DATA_WIDTH-1:0] model_mem [DEPTH];
  logic [1:0]            last_bresp = 2'b11;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r_beats = 0;
  int b_count = 0;
  int ar_hs_cyc = 0;
  bit lat_armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] got,
                       input logic [DATA_WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare process: evaluated on the falling edge, where a valid&&ready seen
  // now is the handshake that completes on the next rising edge.
  initial begin
    logic                  prev_rstall, prev_bstall, prev_rvalid;
    logic [DATA_WIDTH-1:0] prev_rdata;
    logic [6:0]            prev_rctl;
    logic [5:0]            prev_b;
    r_exp_t                re;
    b_exp_t                be;
    prev_rstall = 1'b0;
    prev_bstall = 1'b0;
    prev_rvalid = 1'b0;
    prev_rdata  = '0;
    prev_rctl   = '0;
    prev_b      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rstall = 1'b0;
        prev_bstall = 1'b0;
        prev_rvalid = 1'b0;
      end else begin
        if (prev_rstall) begin
          check("r_hold_valid", rvalid, 1);
          check("r_hold_data", rdata, prev_rdata);
          check("r_hold_ctl", {rid, rresp, rlast}, prev_rctl);
        end
        if (prev_bstall) begin
          check("b_hold_valid", bvalid, 1);
          check("b_hold_ctl", {bid, bresp}, prev_b);
        end
        if (rvalid && !prev_rvalid && lat_armed) begin
          check("r_latency", cyc - ar_hs_cyc, RD_LAT);
          lat_armed = 1'b0;
        end
        if (rvalid && rready) begin
          r_beats++;
          got_r.push_back(rdata);
          if (exp_r.size() == 0) check("r_unexpected", rvalid, 0);
          else begin
            re = exp_r.pop_front();
            check("r_data", rdata, re.data);
            check("r_id", rid, re.id);
            check("r_resp", rresp, re.resp);
            check("r_last", rlast, re.last);
          end
        end
        if (bvalid && bready) begin
          b_count++;
          last_bresp = bresp;
          if (exp_b.size() == 0) check("b_unexpected", bvalid, 0);
          else begin
            be = exp_b.pop_front();
            check("b_id", bid, be.id);
            check("b_resp", bresp, be.resp);
          end
        end
        prev_rstall = rvalid && !rready;
        prev_bstall = bvalid && !bready;
        prev_rvalid = rvalid;
        prev_rdata  = rdata;
        prev_rctl   = {rid, rresp, rlast};
        prev_b      = {bid, bresp};
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < TMO) begin n++; @(negedge clk); end
    if (!awready) check("aw_timeout", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w_beat(input logic [DATA_WIDTH-1:0] d, input logic [15:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < TMO) begin n++; @(negedge clk); end
    if (!wready) check("w_timeout", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Beat i carries base + i*step; wlast goes on the last of nbeats beats sent.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [DATA_WIDTH-1:0] base, input logic [DATA_WIDTH-1:0] step,
                             input logic [15:0] strb, input int nbeats);
    bit ok;
    b_exp_t be;
    int n = 0;
    ok = (size == 3'd4) && (burst == 2'b01) && (nbeats == int'(len) + 1);
    send_aw(id, addr, len, size, burst);
    be.id = id; be.resp = ok ? 2'b00 : 2'b10;
    exp_b.push_back(be);
    for (int i = 0; i < nbeats; i++) begin
      logic [DATA_WIDTH-1:0] d;
      int idx;
      d = base + DATA_WIDTH'(i) * step;
      idx = ((addr >> 4) + i) % DEPTH;
      send_w_beat(d, strb, i == nbeats - 1);
      if (ok) for (int b = 0; b < 16; b++) if (strb[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    @(negedge clk);
    while (exp_b.size() != 0 && n < TMO) begin n++; @(negedge clk); end
    if (exp_b.size() != 0) check("b_timeout", exp_b.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit legal;
    r_exp_t re;
    int n = 0;
    legal = (size == 3'd4) && (burst == 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      re.id   = id;
      re.data = legal ? model_mem[((addr >> 4) + i) % DEPTH] : '0;
      re.resp = legal ? 2'b00 : 2'b10;
      re.last = (i == int'(len));
      exp_r.push_back(re);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < TMO) begin n++; @(negedge clk); end
    if (!arready) check("ar_timeout", arready, 1);
    ar_hs_cyc = cyc + 1;
    lat_armed = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (exp_r.size() != 0 && n < TMO) begin n++; @(negedge clk); end
    if (exp_r.size() != 0) check("r_timeout", exp_r.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, b0, n;

    // Reset values
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-beat write then read at 0x0
    write_burst(4'h0, 32'h0, 8'd1, 3'd4, 2'b01, {8{32'h01234567}}, '0, 16'hFFFF, 2);
    check("t1_bresp_lit", last_bresp, 2'b00);
    got_r.delete();
    read_burst(4'h0, 32'h0, 8'd1, 3'd4, 2'b01);
    check("t1_nbeats", got_r.size(), 2);
    if (got_r.size() == 2) begin
      check("t1_beat0_lit", got_r[0], {8{32'h01234567}});
      check("t1_beat1_lit", got_r[1], {8{32'h01234567}});
    end

    // Partial strobe over a zeroed entry
    write_burst(4'h1, 32'h20, 8'd0, 3'd4, 2'b01, '0, '0, 16'hFFFF, 1);
    write_burst(4'h2, 32'h20, 8'd0, 3'd4, 2'b01, 128'hFFEEDDCCBBAA9988_8877665544332211, '0,
                16'h00FF, 1);
    got_r.delete();
    read_burst(4'h2, 32'h20, 8'd0, 3'd4, 2'b01);
    if (got_r.size() == 1) check("t2_strb_lit", got_r[0], 128'h0000000000000000_8877665544332211);
    else check("t2_nbeats", got_r.size(), 1);

    // Illegal size: write rejected, memory untouched, illegal read returns error and zero
    write_burst(4'h3, 32'h40, 8'd0, 3'd4, 2'b01, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0, '0,
                16'hFFFF, 1);
    write_burst(4'h4, 32'h40, 8'd0, 3'd3, 2'b01, 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD, '0,
                16'hFFFF, 1);
    check("t3_bresp_lit", last_bresp, 2'b10);
    got_r.delete();
    read_burst(4'h5, 32'h40, 8'd0, 3'd4, 2'b01);
    read_burst(4'h6, 32'h40, 8'd0, 3'd3, 2'b01);
    if (got_r.size() == 2) begin
      check("t3_unchanged_lit", got_r[0], 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0);
      check("t3_err_rdata_lit", got_r[1], 128'h0);
    end else check("t3_nbeats", got_r.size(), 2);

    // Beat-count mismatch: early wlast, then missing wlast
    write_burst(4'h7, 32'h500, 8'd1, 3'd4, 2'b01, 128'h77, '0, 16'hFFFF, 1);
    check("t3_early_last_lit", last_bresp, 2'b10);
    write_burst(4'h8, 32'h600, 8'd0, 3'd4, 2'b01, 128'h88, '0, 16'hFFFF, 2);
    check("t3_late_last_lit", last_bresp, 2'b10);

    // Wrap past the last entry, plus aliasing of upper address bits
    write_burst(4'h9, 32'hFE0, 8'd3, 3'd4, 2'b01, 128'h1000, 128'h1, 16'hFFFF, 4);
    read_burst(4'h9, 32'hFE0, 8'd3, 3'd4, 2'b01);
    got_r.delete();
    read_burst(4'hA, 32'h0, 8'd1, 3'd4, 2'b01);
    read_burst(4'hB, 32'h10FE0, 8'd0, 3'd4, 2'b01);
    if (got_r.size() == 3) begin
      check("t4_entry0_lit", got_r[0], 128'h1002);
      check("t4_entry1_lit", got_r[1], 128'h1003);
      check("t4_alias_lit", got_r[2], 128'h1000);
    end else check("t4_nbeats", got_r.size(), 3);

    // Concurrent stalled read and held write response
    r0 = r_beats; b0 = b_count;
    bready = 1'b0;
    fork
      write_burst(4'hC, 32'h100, 8'd0, 3'd4, 2'b01, 128'hABCD, '0, 16'hFFFF, 1);
      read_burst(4'hD, 32'hFE0, 8'd3, 3'd4, 2'b01);
      begin
        for (int k = 0; k < 40; k++) begin
          rready = (k % 4 == 0) || (k % 4 == 3);
          @(posedge clk); #1;
        end
        rready = 1'b1;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!bvalid && n < TMO) begin n++; @(negedge clk); end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 bready = 1'b1;
      end
    join
    check("t5_r_beats", r_beats - r0, 4);
    check("t5_b_count", b_count - b0, 1);

    // Reset during a four-beat write after its first beat
    b0 = b_count;
    send_aw(4'h3, 32'h300, 8'd3, 3'd4, 2'b01);
    send_w_beat(128'h5555_6666_7777_8888, 16'hFFFF, 1'b0);
    model_mem[48] = 128'h5555_6666_7777_8888;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_wready", wready, 0);
    check("t6_rst_bvalid", bvalid, 0);
    check("t6_rst_awready", awready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_wready", wready, 0);
    check("t6_post_awready", awready, 1);
    check("t6_post_bvalid", bvalid, 0);
    @(posedge clk); #1;
    got_r.delete();
    read_burst(4'hE, 32'h300, 8'd0, 3'd4, 2'b01);
    if (got_r.size() == 1) check("t6_beat1_lit", got_r[0], 128'h5555_6666_7777_8888);
    else check("t6_nbeats", got_r.size(), 1);
    check("t6_no_b", b_count - b0, 0);

    check("end_exp_r_empty", exp_r.size(), 0);
    check("end_exp_b_empty", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
